// File: rtl/assign_checker.sv
// Checks three AND implementations (combinational, registered, always-block) against a&b
// over a run of len samples, reporting an error count, first failing index and sticky flags.
module assign_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             a,
  input  logic             b,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       err_flags
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [2:0]       flags_q, flags_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ab_q;
  logic             ab;
  logic [2:0]       miss;

  assign ab = a & b;

  // The registered copy has no history on the first sample, so its check is masked there.
  always_comb begin
    miss[0] = (c1 != ab);
    miss[1] = (idx_q != '0) && (c2 != ab_q);
    miss[2] = (c3 != ab);
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    flags_d = flags_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          idx_d   = '0;
          cnt_d   = '0;
          fidx_d  = '0;
          flags_d = '0;
          if (len == '0) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        idx_d = idx_q + ONE;
        if (|miss) begin
          flags_d = flags_q | miss;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + ONE;
          // A saturating count never returns to zero, so zero means no mismatch yet.
          if (cnt_q == '0) fidx_d = idx_q;
        end
        if (idx_q == len_q - ONE) begin
          state_d = DONE;
          pass_d  = (cnt_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fidx_q  <= '0;
      flags_q <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      flags_q <= flags_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ab_q    <= ab;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = cnt_q;
  assign first_err_idx = fidx_q;
  assign err_flags     = flags_q;

endmodule

// File: tb/tb_assign_checker.sv
// Table-driven bench for assign_checker: run results are queued when a run starts and
// compared when the done pulse appears; corner cases are hand-written sequences.
module tb_assign_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, a, b, c1, c2, c3;
  logic [15:0] len;
  logic        busy, done, pass;
  logic [15:0] err_cnt, first_err_idx;
  logic [2:0]  err_flags;

  logic        start_s;
  logic [1:0]  len_s;
  logic        busy_s, done_s, pass_s;
  logic [1:0]  err_cnt_s, first_err_idx_s;
  logic [2:0]  err_flags_s;

  always #5 clk = ~clk;

  assign_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .a(a), .b(b), .c1(c1), .c2(c2), .c3(c3),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .err_flags(err_flags)
  );

  assign_checker #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .len(len_s),
    .a(a), .b(b), .c1(c1), .c2(c2), .c3(c3),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
    .first_err_idx(first_err_idx_s), .err_flags(err_flags_s)
  );

  typedef struct {
    logic [15:0] len;
    logic        pre;        // a=b value in the start cycle
    logic [7:0]  va, vb;     // per-sample operands
    logic [7:0]  m1, m2, m3; // per-sample fault masks XORed onto the correct c1/c2/c3
    bit          mid_start;
    logic [15:0] exp_cnt, exp_idx;
    logic [2:0]  exp_flags;
    logic        exp_pass;
  } vec_t;

  typedef struct {
    logic        pass;
    logic [15:0] cnt, idx;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t got_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[9];
  vec_t rec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        got_e = sb_q.pop_front();
        check("sb_pass", pass, got_e.pass);
        check("sb_err_cnt", err_cnt, got_e.cnt);
        check("sb_first_err_idx", first_err_idx, got_e.idx);
        check("sb_err_flags", err_flags, got_e.flags);
      end
    end
  end

  task automatic do_run(input vec_t v);
    exp_t e;
    logic prev, ab;
    e.pass = v.exp_pass; e.cnt = v.exp_cnt; e.idx = v.exp_idx; e.flags = v.exp_flags;
    sb_q.push_back(e);
    a = v.pre; b = v.pre; c1 = v.pre; c3 = v.pre; c2 = 1'b0;
    start = 1'b1; len = v.len;
    prev = v.pre;
    tick();
    for (int i = 0; i < int'(v.len); i++) begin
      ab = v.va[i] & v.vb[i];
      a  = v.va[i];
      b  = v.vb[i];
      c1 = ab ^ v.m1[i];
      c2 = prev ^ v.m2[i];
      c3 = ab ^ v.m3[i];
      prev  = ab;
      start = v.mid_start && (i == 1);
      len   = v.mid_start ? 16'd1 : 16'd0;
      check("busy_in_run", busy, 1);
      tick();
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_after_run", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_err_cnt_held", err_cnt, v.exp_cnt);
    check("idle_flags_held", err_flags, v.exp_flags);
    check("idle_pass_held", pass, v.exp_pass);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; a = 0; b = 0; c1 = 0; c2 = 0; c3 = 0;
    start_s = 1'b0; len_s = '0;

    tbl[0] = '{16'd8, 1'($urandom), 8'($urandom), 8'($urandom), 8'h00, 8'h00, 8'h00, 0,
               16'd0, 16'd0, 3'b000, 1'b1};
    tbl[1] = '{16'd4, 1'b0, 8'h0F, 8'h0F, 8'h00, 8'h01, 8'h00, 0, 16'd0, 16'd0, 3'b000, 1'b1};
    tbl[2] = '{16'd5, 1'b0, 8'h14, 8'h14, 8'h00, 8'h00, 8'h14, 0, 16'd2, 16'd2, 3'b100, 1'b0};
    tbl[3] = '{16'd3, 1'b0, 8'h05, 8'h07, 8'h02, 8'h02, 8'h00, 0, 16'd1, 16'd1, 3'b011, 1'b0};
    tbl[4] = '{16'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd0, 16'd0, 3'b000, 1'b1};
    tbl[5] = '{16'd4, 1'b1, 8'h0A, 8'h0E, 8'h00, 8'h00, 8'h00, 1, 16'd0, 16'd0, 3'b000, 1'b1};
    tbl[6] = '{16'd6, 1'b0, 8'h3F, 8'h3F, 8'h20, 8'h00, 8'h00, 0, 16'd1, 16'd5, 3'b001, 1'b0};
    tbl[7] = '{16'd2, 1'b1, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 0, 16'd1, 16'd0, 3'b101, 1'b0};
    tbl[8] = '{16'd1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 16'd0, 16'd0, 3'b000, 1'b1};

    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err_idx", first_err_idx, 0);
    check("rst_err_flags", err_flags, 0);
    check("rst_s_err_cnt", err_cnt_s, 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) do_run(tbl[i]);

    // Reset in the middle of a faulty len=8 run.
    start = 1'b1; len = 16'd8; a = 0; b = 0; c1 = 0; c2 = 0; c3 = 0;
    tick();
    start = 1'b0; len = '0;
    for (int i = 0; i < 3; i++) begin
      a = 1; b = 1; c1 = 0; c2 = 1; c3 = 1;
      tick();
    end
    check("pre_reset_err_cnt", err_cnt, 3);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_first_err_idx", first_err_idx, 0);
    check("midrst_flags", err_flags, 0);
    check("midrst_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst_no_done", done, 0);
    end
    rec = '{16'd2, 1'b0, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 0, 16'd0, 16'd0, 3'b000, 1'b1};
    do_run(rec);

    // Two-bit counter: three failing samples must read back as 3 and stay there.
    start_s = 1'b1; len_s = 2'd3; a = 0; b = 0; c1 = 0; c2 = 0; c3 = 0;
    tick();
    start_s = 1'b0; len_s = '0;
    for (int i = 0; i < 3; i++) begin
      a = 1; b = 1; c1 = 0; c2 = 1; c3 = 1;
      check("sat_busy", busy_s, 1);
      tick();
    end
    check("sat_done", done_s, 1);
    check("sat_err_cnt", err_cnt_s, 3);
    check("sat_pass", pass_s, 0);
    check("sat_flags", err_flags_s, 3'b001);
    check("sat_first_idx", first_err_idx_s, 0);
    tick();
    check("sat_no_wrap", err_cnt_s, 3);
    check("sat_done_cleared", done_s, 0);

    tick();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/assign_checker.md
ASSIGN_CHECKER -- requirements
Module: assign_checker

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16: width of the sample-length, error-count and error-index fields.
REQ-002 The module SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have input rst_n, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have input start, 1 bit: single-cycle request to begin a check run.
REQ-005 The module SHALL have input len, CNT_W bits: number of samples in the run, captured when start is accepted.
REQ-006 The module SHALL have inputs a and b, 1 bit each: stimulus operands also driven to the unit under check.
REQ-007 The module SHALL have input c1, 1 bit: the unit's combinational AND result, expected equal to a&b in the same cycle.
REQ-008 The module SHALL have input c2, 1 bit: the unit's registered AND result, expected equal to a&b of the previous cycle.
REQ-009 The module SHALL have input c3, 1 bit: the unit's always-block combinational AND result, expected equal to a&b in the same cycle.
REQ-010 The module SHALL have output busy, 1 bit: high while a run is in progress.
REQ-011 The module SHALL have output done, 1 bit: single-cycle pulse marking run completion.
REQ-012 The module SHALL have output pass, 1 bit: high when the last completed run had zero mismatches.
REQ-013 The module SHALL have output err_cnt, CNT_W bits: mismatching-sample count of the current or last run.
REQ-014 The module SHALL have output first_err_idx, CNT_W bits: sample index of the first mismatch.
REQ-015 The module SHALL have output err_flags, 3 bits: sticky per-output mismatch flags; bit0=c1, bit1=c2, bit2=c3.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE; all outputs registered.
REQ-017 In IDLE, start=1 with len!=0 SHALL move to RUN on that edge, capture len, zero the sample index, and clear err_cnt, first_err_idx, err_flags and pass.
REQ-018 In IDLE, start=1 with len==0 SHALL go directly to DONE with err_cnt=0 and pass=1.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 Each RUN cycle SHALL be one sample, index 0..len-1, taken on the rising edge.
REQ-021 On each sample, c1 SHALL be checked against a&b and c3 against a&b.
REQ-022 c2 SHALL be checked against a registered copy of a&b from the previous cycle; the c2 check SHALL be masked on sample index 0.
REQ-023 The registered a&b copy SHALL update every cycle in every state, so that it reflects the cycle before sample 0.
REQ-024 Any mismatch on a sample SHALL increment err_cnt by exactly 1, regardless of how many of c1/c2/c3 mismatch.
REQ-025 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Each mismatching output SHALL set its err_flags bit; set bits SHALL stay set until the next accepted start or reset.
REQ-027 first_err_idx SHALL capture the sample index on the first mismatch of a run and hold thereafter; it SHALL be 0 if no mismatch occurs.
REQ-028 On the sample with index len-1, the FSM SHALL move to DONE.
REQ-029 In DONE, done=1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-030 pass SHALL be set to 1 when DONE is entered if err_cnt==0 (counting the final sample), else 0, and SHALL hold until the next accepted start.
REQ-031 busy SHALL equal 1 exactly while in RUN.
REQ-032 err_cnt, first_err_idx and err_flags SHALL remain readable in IDLE until the next accepted start.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force the FSM to IDLE and set busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, err_flags=0, and the registered a&b copy to 0.
REQ-034 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-035 Clean run: len=8, a/b random, c1=c3=a&b, c2 = a&b delayed one cycle -> busy high 8 cycles, done pulse, pass=1, err_cnt=0, err_flags=0.
REQ-036 c2 fault: len=4, a=b=1 on every sample, a=b=0 the cycle before start, c2 driven 1 from sample 0 -> sample 0 masked; err_cnt=0, pass=1.
REQ-037 c3 stuck-at-0: len=5, a=b=1 on samples 2 and 4 only -> err_cnt=2, first_err_idx=2, err_flags=3'b100, pass=0.
REQ-038 Multiple faults: len=3, c1 and c2 both wrong on sample 1 -> err_cnt=1, err_flags=3'b011, first_err_idx=1.
REQ-039 Boundaries: start with len=0 -> done the next cycle, pass=1. Start pulsed during RUN -> run unaffected. CNT_W=2 with len=3 and all samples failing -> err_cnt=3 (saturation exercised by forcing len=3 with 3 failures then checking no wrap).
REQ-040 Reset mid-run: assert rst_n=0 at sample 3 of len=8 -> next cycle busy=0, err_cnt=0, done never pulses; new start with len=2 completes normally.
